pmod_input_conditioner: RTL

Parametrised front end for active-low Pmod inputs on the JA header, replacing the plain inverter path to the LEDs. Each channel is synchronised, polarity-corrected, debounced and edge-detected. Outputs are clean levels for the LEDs and downstream logic, one-cycle rise/fall pulses, and a shared rising-edge event counter. Sits between the top-level JA pins and all user logic.

---
 rtl/pmod_input_conditioner.sv | 109 ++++++++++
 1 files changed

// File: rtl/pmod_input_conditioner.sv
// Front end for active-low Pmod pins: 2-flop sync, polarity fix, per-channel
// debounce, registered rise/fall pulses and a shared rising-edge event counter.
module pmod_input_conditioner #(
    parameter int                  CHANNELS        = 4,
    parameter int                  DEBOUNCE_CYCLES = 1000000,
    parameter logic [CHANNELS-1:0] INVERT_MASK     = {CHANNELS{1'b1}},
    parameter int                  COUNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] ja_in,
    input  logic                clr_count,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_active,
    output logic [COUNT_W-1:0]  event_count
);

    localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic [COUNT_W-1:0] popcount(input logic [CHANNELS-1:0] v);
        logic [COUNT_W-1:0] sum;
        sum = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sum = sum + COUNT_W'(v[k]);
        end
        return sum;
    endfunction

    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic [CHANNELS-1:0] norm;
    logic [CHANNELS-1:0] led_q, led_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [COUNT_W-1:0]  count_q, count_d;

    // Sync flops reset to the idle raw level so no spurious edge follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= INVERT_MASK;
            sync2_q <= INVERT_MASK;
        end else begin
            sync1_q <= ja_in;
            sync2_q <= sync1_q;
        end
    end

    assign norm = sync2_q ^ INVERT_MASK;

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the window.
    always_comb begin
        led_d  = led_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (norm[i] != led_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    led_d[i]  = norm[i];
                    rise_d[i] = norm[i];
                    fall_d[i] = ~norm[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            led_q  <= led_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Clear drops the old total but still adds the pulses visible this cycle.
    assign count_d = (clr_count ? '0 : count_q) + popcount(rise_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign led         = led_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign any_active  = |led_q;
    assign event_count = count_q;

endmodule
